// File: rtl/axis_uart_pkg.sv
`default_nettype none
// ==================================================================
// axis_uart_pkg : shared types and constants for the UART receiver.
// Rev 1.0
// ==================================================================
package axis_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [3:0]  PAR_ZERO    = 4'd0;
  localparam logic [3:0]  PAR_ONE     = 4'd1;
  localparam logic [3:0]  PAR_ODD     = 4'd2;
  localparam logic [3:0]  PAR_EVEN    = 4'd3;
  localparam logic [3:0]  STOP_TWO    = 4'd2;
  localparam logic [31:0] MIN_DELITEL = 32'd3;

  function automatic logic expected_parity(input logic [3:0] mode, input logic [7:0] data);
    case (mode)
      PAR_ONE:  return 1'b1;
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ==================================================================
// uart_rx_sync : line synchroniser, falling-edge pulse, bit value.
// Rev 1.0 | option: UART_RX_MAJORITY_EN (2-of-3 vote around centre)
// ==================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic bit_o,
  output logic fall_o
);

  logic meta_q, sync_q, dly_q, fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      fall_q <= dly_q & ~sync_q;
    end
  end

  // dly_q is the nominal sample; sync_q and old_q are its +1/-1 neighbours
`ifdef UART_RX_MAJORITY_EN
  logic old_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) old_q <= 1'b1;
    else     old_q <= dly_q;
  end

  assign bit_o = (sync_q & dly_q) | (sync_q & old_q) | (dly_q & old_q);
`else
  assign bit_o = dly_q;
`endif

  assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/axis_uart_rx.sv
`default_nettype none
// ==================================================================
// axis_uart_rx : UART receiver presenting bytes on an AXI-Stream port.
// Rev 1.0 | option: UART_RX_MAJORITY_EN (3-sample bit voting)
// ==================================================================
module axis_uart_rx
  import axis_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [7:0]  maxis_data_o,
  output logic        maxis_tvalid_o,
  input  logic        maxis_tready_i,
  input  logic [31:0] delitel,
  input  logic [3:0]  stop_bit_num,
  input  logic [3:0]  parity_bit_mode,
  output logic        parity_err_o,
  output logic        frame_err_o,
  output logic        overrun_err_o
);

  rx_state_e   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] div_q, div_d;
  logic [3:0]  mode_q, mode_d;
  logic        stop2_q, stop2_d;
  logic [2:0]  bitn_q, bitn_d;
  logic [7:0]  shift_q, shift_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        stopn_q, stopn_d;

  logic [7:0]  data_q;
  logic        tvalid_q, perr_pls_q, ferr_pls_q, ovr_pls_q;

  logic        w_bit, w_fall, w_tick;
  logic [31:0] w_half;
  logic        w_last_stop, w_done, w_accept, w_bad_frame;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (uart_rx),
    .bit_o  (w_bit),
    .fall_o (w_fall)
  );

  // Start bit is sampled half a period in; every later bit a full period on
  assign w_half = 32'(({1'b0, div_q} + 33'd1) >> 1);
  assign w_tick = (state_q == ST_START) ? (cnt_q == w_half) : (cnt_q == div_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= MIN_DELITEL;
      mode_q  <= PAR_ZERO;
      stop2_q <= 1'b0;
      bitn_q  <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      stopn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      stop2_q <= stop2_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      stopn_q <= stopn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    div_d   = div_q;
    mode_d  = mode_q;
    stop2_d = stop2_q;
    bitn_d  = bitn_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    stopn_d = stopn_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (w_fall) begin
          state_d = ST_START;
          div_d   = (delitel < MIN_DELITEL) ? MIN_DELITEL : delitel;
          mode_d  = parity_bit_mode;
          stop2_d = (stop_bit_num == STOP_TWO);
        end
      end
      ST_START: begin
        if (w_tick) begin
          cnt_d  = '0;
          bitn_d = '0;
          state_d = w_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          cnt_d   = '0;
          shift_d = {w_bit, shift_q[7:1]};
          bitn_d  = bitn_q + 3'd1;
          if (bitn_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          cnt_d   = '0;
          perr_d  = (w_bit != expected_parity(mode_q, shift_q));
          ferr_d  = 1'b0;
          stopn_d = 1'b0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          cnt_d   = '0;
          ferr_d  = ferr_q | ~w_bit;
          stopn_d = 1'b1;
          if (w_last_stop) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_last_stop = ~stop2_q | stopn_q;
    w_done      = (state_q == ST_STOP) & w_tick & w_last_stop;
    w_accept    = ~tvalid_q | maxis_tready_i;
    w_bad_frame = ferr_q | ~w_bit;
  end

  // Single-entry output stage; a byte arriving while it is full is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      tvalid_q   <= 1'b0;
      perr_pls_q <= 1'b0;
      ferr_pls_q <= 1'b0;
      ovr_pls_q  <= 1'b0;
    end else begin
      perr_pls_q <= w_done & perr_q;
      ferr_pls_q <= w_done & w_bad_frame;
      ovr_pls_q  <= w_done & ~w_accept;
      if (w_done && w_accept) begin
        data_q   <= shift_q;
        tvalid_q <= 1'b1;
      end else if (maxis_tready_i) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign maxis_data_o   = data_q;
  assign maxis_tvalid_o = tvalid_q;
  assign parity_err_o   = perr_pls_q;
  assign frame_err_o    = ferr_pls_q;
  assign overrun_err_o  = ovr_pls_q;

endmodule
`default_nettype wire

// File: doc/axis_uart_rx.md
# axis_uart_rx

UART receiver forming the receive half of the UART link: deserialises frames in the format produced by the transmit stage and presents each byte on an AXI-Stream master port. It takes the same APB-register configuration as the transmitter: divider, stop-bit count and parity mode. It reports parity, framing and overrun errors as single-cycle pulses.

## Interface
- No parameters; data width fixed at 8.
- `clk`  in  1  system clock; everything in this block runs on its rising edge.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `uart_rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `maxis_data_o`  out  8  received byte.
- `maxis_tvalid_o`  out  1  byte valid.
- `maxis_tready_i`  in  1  downstream ready.
- `delitel`  in  32  bit period minus one, in clocks.
- `stop_bit_num`  in  4  value 2 selects two stop bits; any other value selects one.
- `parity_bit_mode`  in  4  0 = constant 0, 1 = constant 1, 2 = odd, 3 = even, other values = constant 0.
- `parity_err_o`  out  1  pulse: parity bit mismatch.
- `frame_err_o`  out  1  pulse: a stop bit sampled low.
- `overrun_err_o`  out  1  pulse: received byte dropped.

## Operation
- Frame format: start (0), 8 data bits LSB first, one parity bit (always present), then 1 or 2 stop bits (1).
- Expected parity bit: mode 0 → 0; 1 → 1; 2 → ~^data; 3 → ^data; other → 0.
- Bit period P = `delitel`+1 clocks. Effective `delitel` = max(`delitel`, 3).
- Line input: 2-flop synchroniser, followed by a falling-edge detector on the synchronised signal.
- Configuration (`delitel`, stop count, parity mode) is latched on the start edge and held for the whole frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START on a detected 1→0 edge. The bit counter is cleared on entry.
- START: sample at count = P>>1.
  - If the sample is 1 (false start): return to IDLE with no output.
  - Else go to DATA with count reset.
- DATA: sample every P clocks; shift into bit[7:0] LSB first. After 8 samples → PARITY.
- PARITY: one sample at P; compare with the expected parity bit; → STOP.
- STOP: 1 or 2 samples at P intervals. After the last stop sample → IDLE immediately, so back-to-back frames are accepted.
- Output register (one entry):
  - On frame completion, if `maxis_tvalid_o`=0 or `maxis_tready_i`=1 that cycle, load the byte and set tvalid.
  - Otherwise drop the new byte and pulse `overrun_err_o`. The held byte is unchanged.
- tvalid clears on the tvalid & tready handshake, unless a new byte loads in the same cycle.
- `parity_err_o` and `frame_err_o` pulse in the completion cycle. The byte is still delivered.
- A line held low (break) produces frame_err once, then stays in IDLE until a fresh 1→0 edge.

## Timing
- Reset values: `maxis_data_o`=0, `maxis_tvalid_o`=0, all error pulses 0, FSM in IDLE, synchroniser flops 1.
- Reset asserted mid-frame aborts the frame; no output is produced.
- Start edge is detected 3 clocks after the line transition (2 synchroniser flops + edge register).
- Data bit k (0..7) is sampled (P>>1) + (k+1)·P clocks after edge detection.
- `maxis_tvalid_o` rises 1 clock after the last stop sample. Error pulses are aligned with that rise; overrun is aligned with the drop cycle.
- `maxis_data_o` is stable while tvalid=1 and tready=0.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit value is the 2-of-3 majority of samples at the nominal point −1, 0 and +1 clocks. This applies to start, data, parity and stop bits.
- Not defined: a single sample at the nominal point. Latency is identical in both builds.

## Structure
- Package `axis_uart_pkg`:
  - FSM state enum.
  - Parity mode constants `PAR_ZERO`=0, `PAR_ONE`=1, `PAR_ODD`=2, `PAR_EVEN`=3.
  - `STOP_TWO`=2.
  - `MIN_DELITEL`=3.
- Sub-module `uart_rx_sync`: 2-flop synchroniser plus falling-edge pulse, reset to 1.

## Test plan
- `delitel`=15, mode 3, 1 stop; send 0xA5 with parity 0, tready=1 → one beat with data 0xA5; no error pulses.
- Mode 2; send 0x3C with parity bit 0 (expected 1) → 0x3C delivered, `parity_err_o` pulses once.
- 1 stop; send 0x55 with stop bit 0 → 0x55 delivered, `frame_err_o` pulses; no second frame until the line rises and falls again.
- tready=0; send 0x11 then 0x22 → data holds 0x11, `overrun_err_o` pulses once; after raising tready, exactly one beat of 0x11.
- Low glitch of 4 clocks with `delitel`=15 → no tvalid and no error pulses; FSM back in IDLE.
- `stop_bit_num`=2; send 0x01 and 0xFE back-to-back with zero gap → two beats in order; assert `rst` mid-way through a third frame → tvalid=0 and no beat.
